// File: rtl/uart_rx_deserializer_if.sv
// UART receive bus: serial line and frame configuration in, parallel word and status strobes out.
// Ports: rx_in, prescale, par_en, par_typ (master->slave); p_data, data_valid, par_err, stp_err (slave->master).
interface uart_rx_deserializer_if #(
    parameter int DWIDTH     = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [DWIDTH-1:0]     p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output rx_in, prescale, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detect, 3-point majority bit sampling, LSB-first shift,
// optional parity and stop check. Ports: clk, rst (async active-low), bus (slave modport of uart_rx_deserializer_if).
module uart_rx_deserializer #(
    parameter int DWIDTH     = 8,
    parameter int PRESCALE_W = 6
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_deserializer_if.slave bus
);
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] ONE = 1;
    localparam logic [BW-1:0] LAST = BW'(DWIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic                  rx_meta, rx_s;
    logic [PRESCALE_W-1:0] pre_r, edge_cnt, half;
    logic                  par_en_r, par_typ_r;
    logic [BW-1:0]         bit_cnt;
    logic [DWIDTH-1:0]     shift_reg, p_data_r;
    logic                  samp_a, samp_b, sample, par_bad;
    logic                  dv_r, pe_r, se_r;
    logic                  bit_end, last_bit;
    logic                  cfg_load, shift_en, par_chk, frame_end;

    assign half     = pre_r >> 1;
    assign bit_end  = (state != IDLE) && (edge_cnt == pre_r - ONE);
    assign last_bit = (bit_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (!rx_s) state_nx = START;
            START:  if (bit_end) state_nx = sample ? IDLE : DATA;
            DATA:   if (bit_end && last_bit) state_nx = par_en_r ? PARITY : STOP;
            PARITY: if (bit_end) state_nx = STOP;
            STOP:   if (bit_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_load  = (state == IDLE) && !rx_s;
        shift_en  = (state == DATA) && bit_end;
        par_chk   = (state == PARITY) && bit_end;
        frame_end = (state == STOP) && bit_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            pre_r     <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            sample    <= 1'b1;
            shift_reg <= '0;
            par_bad   <= 1'b0;
            p_data_r  <= '0;
            dv_r      <= 1'b0;
            pe_r      <= 1'b0;
            se_r      <= 1'b0;
        end else begin
            rx_meta <= bus.rx_in;
            rx_s    <= rx_meta;
            dv_r    <= 1'b0;
            pe_r    <= 1'b0;
            se_r    <= 1'b0;

            if (cfg_load) begin
                pre_r     <= bus.prescale;
                par_en_r  <= bus.par_en;
                par_typ_r <= bus.par_typ;
            end

            if (state == IDLE || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end

            // Three taps straddling mid-bit; the vote lands well before bit end.
            if (state != IDLE) begin
                if (edge_cnt == half - ONE) samp_a <= rx_s;
                if (edge_cnt == half) samp_b <= rx_s;
                if (edge_cnt == half + ONE) begin
                    sample <= (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
                end
            end

            if (state == START) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end else if (shift_en) begin
                shift_reg[bit_cnt] <= sample;
                bit_cnt            <= bit_cnt + 1'b1;
            end

            if (par_chk) begin
                par_bad <= sample != (^shift_reg ^ par_typ_r);
            end

            if (frame_end) begin
                se_r <= ~sample;
                pe_r <= par_en_r & par_bad;
                if (sample && !(par_en_r && par_bad)) begin
                    p_data_r <= shift_reg;
                    dv_r     <= 1'b1;
                end
            end
        end
    end

    assign bus.p_data     = p_data_r;
    assign bus.data_valid = dv_r;
    assign bus.par_err    = pe_r;
    assign bus.stp_err    = se_r;
endmodule
